fb_fetch: RTL and testbench

FB_FETCH -- requirements
Module: fb_fetch

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_fetch_if.sv | 29 ++
 rtl/fwft_fifo.sv | 69 ++++++
 rtl/fb_fetch.sv | 124 ++++++++++++
 tb/tb_fb_fetch.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer fetch engine: parameter defaults and FSM states.
package fb_pkg;

    localparam int FIFO_DEPTH_DEF      = 64;
    localparam int WORDS_PER_FRAME_DEF = 196608;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_fetch_if.sv
// Memory read channel plus pixel-word FIFO read side of the frame-buffer fetch engine.
interface fb_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;
    logic [31:0]       pixel_word;
    logic              pixel_empty_n;
    logic              pixel_deq;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output pixel_word, pixel_empty_n,
        input  pixel_deq
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  pixel_word, pixel_empty_n,
        output pixel_deq
    );
endinterface

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO with synchronous flush; storage is intentionally not reset.
module fwft_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty_n,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_n_r;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic [CNT_W-1:0] count_nxt_s;

    // Qualified push/pop and next occupancy; a pop frees the slot a push at full needs.
    always_comb begin
        full_s      = (count_r == CNT_W'(DEPTH));
        pop_s       = pop & empty_n_r;
        push_s      = push & (~full_s | pop_s);
        count_nxt_s = count_r;
        if (push_s & ~pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s & ~push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and registered non-empty flag.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r  <= PTR_W'(0);
            rd_ptr_r  <= PTR_W'(0);
            count_r   <= CNT_W'(0);
            empty_n_r <= 1'b0;
        end else begin
            wr_ptr_r  <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r  <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            count_r   <= count_nxt_s;
            empty_n_r <= (count_nxt_s != CNT_W'(0));
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout    = mem_r[rd_ptr_r];
    assign empty_n = empty_n_r;
    assign count   = count_r;

endmodule

// File: rtl/fb_fetch.sv
// Frame-buffer fetch engine: issues credit-limited word reads for one frame into a pixel FIFO.
module fb_fetch
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
    parameter int ADDR_W          = 32
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              busy,
    fb_fetch_if.master        bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int DROP_W = CNT_W + 2;
    localparam int RC_W   = $clog2(WORDS_PER_FRAME + 1);
    localparam logic [RC_W-1:0] WPF_C   = RC_W'(WORDS_PER_FRAME);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    fb_state_e         state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [RC_W-1:0]   req_cnt_r;
    logic [CNT_W-1:0]  outstanding_r;
    logic [DROP_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W-1:0]  out_nxt_s;
    logic [DROP_W-1:0] drop_nxt_s;
    logic [DROP_W-1:0] pend_s;
    logic              fs_s;
    logic              credit_s;
    logic              req_valid_s;
    logic              acc_s;
    logic              resp_s;
    logic              discard_s;
    logic              push_s;

    // Request gating by credit, response steering, and in-flight bookkeeping.
    always_comb begin
        fs_s        = frame_start & enable;
        resp_s      = bus.mem_resp_valid;
        credit_s    = ({1'b0, fifo_count_s} + {1'b0, outstanding_r}) < DEPTH_C;
        req_valid_s = (state_r == ST_FETCH) & (req_cnt_r < WPF_C) & credit_s & ~fs_s;
        acc_s       = req_valid_s & bus.mem_req_ready;
        discard_s   = resp_s & (fs_s | (drop_cnt_r != DROP_W'(0)));
        push_s      = resp_s & ~discard_s;
        pend_s      = drop_cnt_r + DROP_W'(outstanding_r);
        drop_nxt_s  = drop_cnt_r;
        out_nxt_s   = outstanding_r;
        if (fs_s) begin
            // Everything still in flight now belongs to the abandoned frame.
            out_nxt_s  = CNT_W'(0);
            drop_nxt_s = (resp_s && pend_s != DROP_W'(0)) ? pend_s - DROP_W'(1) : pend_s;
        end else begin
            drop_nxt_s = discard_s ? drop_cnt_r - DROP_W'(1) : drop_cnt_r;
            case ({acc_s, push_s})
                2'b10:   out_nxt_s = outstanding_r + CNT_W'(1);
                2'b01:   out_nxt_s = outstanding_r - CNT_W'(1);
                default: out_nxt_s = outstanding_r;
            endcase
        end
    end

    // Fetch FSM with request address and count.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= ADDR_W'(0);
            req_cnt_r <= RC_W'(0);
        end else if (fs_s) begin
            state_r   <= ST_FETCH;
            addr_r    <= fb_base;
            req_cnt_r <= RC_W'(0);
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (acc_s) begin
                        addr_r    <= addr_r + ADDR_W'(4);
                        req_cnt_r <= req_cnt_r + RC_W'(1);
                        if (req_cnt_r + RC_W'(1) == WPF_C) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_IDLE:  state_r <= ST_IDLE;
                ST_DONE:  state_r <= ST_DONE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // Outstanding-read and stale-response counters.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            outstanding_r <= CNT_W'(0);
            drop_cnt_r    <= DROP_W'(0);
        end else begin
            outstanding_r <= out_nxt_s;
            drop_cnt_r    <= drop_nxt_s;
        end
    end

    fwft_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (pix_clk),
        .rst     (rst),
        .flush   (fs_s),
        .push    (push_s),
        .din     (bus.mem_resp_data),
        .pop     (bus.pixel_deq),
        .dout    (bus.pixel_word),
        .empty_n (bus.pixel_empty_n),
        .count   (fifo_count_s)
    );

    assign bus.mem_req_valid = req_valid_s;
    assign bus.mem_req_addr  = addr_r;
    assign busy              = (state_r == ST_FETCH);

endmodule

// File: tb/tb_fb_fetch.sv
// Directed self-checking bench for fb_fetch with a queue-based in-order memory model.
module tb_fb_fetch;
    import fb_pkg::*;

    localparam int DEPTH = 4;
    localparam int WPF   = 8;

    logic        pix_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_start;
    logic [31:0] fb_base;
    logic        busy;
    logic        hold;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] req_log [$];
    logic [31:0] pop_log [$];
    logic [31:0] mem_q   [$];

    fb_fetch_if #(.ADDR_W(32)) bus ();

    fb_fetch #(
        .FIFO_DEPTH      (DEPTH),
        .WORDS_PER_FRAME (WPF),
        .ADDR_W          (32)
    ) dut (
        .pix_clk     (pix_clk),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .fb_base     (fb_base),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log transfers at mid-cycle, then let memory answer (oldest first) for the next cycle.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge pix_clk);
        acc = bus.mem_req_valid & bus.mem_req_ready;
        a   = bus.mem_req_addr;
        if (acc) req_log.push_back(a);
        if (bus.pixel_deq && bus.pixel_empty_n) pop_log.push_back(bus.pixel_word);
        @(posedge pix_clk);
        #1;
        if (acc) mem_q.push_back(a);
        if (!hold && mem_q.size() > 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_q.pop_front() >> 2;
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start = 1'b0; bus.pixel_deq = 1'b0;
        bus.mem_resp_valid = 1'b0; hold = 1'b0;
        mem_q.delete();
        tick();
        mem_q.delete();
        bus.mem_resp_valid = 1'b0;
        tick();
        rst = 1'b0;
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic start_frame(input logic [31:0] base);
        fb_base = base; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        enable = 1'b0; fb_base = 32'h0; frame_start = 1'b0; hold = 1'b0;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = 32'h0; bus.pixel_deq = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_valid",   32'(bus.mem_req_valid), 32'h0);
        chk("rst_addr",    bus.mem_req_addr, 32'h0);
        chk("rst_empty_n", 32'(bus.pixel_empty_n), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_state",   32'(dut.state_r), 32'(ST_IDLE));
        chk("rst_out",     32'(dut.outstanding_r), 32'h0);
        chk("rst_drop",    32'(dut.drop_cnt_r), 32'h0);

        // Full frame with 1-cycle memory and continuous draining
        do_reset();
        enable = 1'b1; bus.mem_req_ready = 1'b1; bus.pixel_deq = 1'b1;
        start_frame(32'h1000);
        chk("s1_busy_fetch", 32'(busy), 32'h1);
        for (int i = 0; i < 40 && req_log.size() < WPF; i++) tick();
        chk("s1_req_cnt",  32'(req_log.size()), 32'd8);
        chk("s1_busy_end", 32'(busy), 32'h0);
        chk("s1_done",     32'(dut.state_r), 32'(ST_DONE));
        for (int i = 0; i < 10; i++) tick();
        chk("s1_req_cnt_after", 32'(req_log.size()), 32'd8);
        chk("s1_valid_after",   32'(bus.mem_req_valid), 32'h0);
        for (int i = 0; i < 8; i++) chk("s1_addr", req_log[i], 32'h1000 + 32'(4 * i));
        chk("s1_pop_cnt", 32'(pop_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("s1_data", pop_log[i], 32'h400 + 32'(i));

        // Credit stall with no draining; one dequeue frees exactly one request
        do_reset();
        enable = 1'b1; bus.mem_req_ready = 1'b1;
        start_frame(32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("s2_req_cnt",  32'(req_log.size()), 32'd4);
        chk("s2_fifo_cnt", 32'(dut.fifo_count_s), 32'd4);
        chk("s2_stalled",  32'(bus.mem_req_valid), 32'h0);
        bus.pixel_deq = 1'b1;
        tick();
        bus.pixel_deq = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("s2_req_cnt2",  32'(req_log.size()), 32'd5);
        chk("s2_pop_cnt",   32'(pop_log.size()), 32'd1);
        chk("s2_pop0",      pop_log[0], 32'h0);
        chk("s2_new_addr",  req_log[4], 32'h10);
        chk("s2_fifo_cnt2", 32'(dut.fifo_count_s), 32'd4);

        // Address held stable under backpressure
        do_reset();
        enable = 1'b1; bus.mem_req_ready = 1'b0;
        start_frame(32'h1000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s3_valid_hold", 32'(bus.mem_req_valid), 32'h1);
            chk("s3_addr_hold", bus.mem_req_addr, 32'h1000);
        end
        chk("s3_no_xfer", 32'(req_log.size()), 32'd0);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("s3_one_xfer",  32'(req_log.size()), 32'd1);
        chk("s3_xfer_addr", req_log[0], 32'h1000);
        chk("s3_next_addr", bus.mem_req_addr, 32'h1004);

        // Restart with three stale reads in flight
        do_reset();
        enable = 1'b1; bus.mem_req_ready = 1'b1; hold = 1'b1;
        start_frame(32'h1000);
        for (int i = 0; i < 20 && req_log.size() < 4; i++) tick();
        chk("s4_req_cnt", 32'(req_log.size()), 32'd4);
        hold = 1'b0;
        tick();
        hold = 1'b1;
        tick(); tick();
        chk("s4_out3",    32'(dut.outstanding_r), 32'd3);
        chk("s4_fifo1",   32'(bus.pixel_empty_n), 32'h1);
        hold = 1'b0;
        start_frame(32'h2000);
        chk("s4_flushed", 32'(bus.pixel_empty_n), 32'h0);
        chk("s4_drop3",   32'(dut.drop_cnt_r), 32'd3);
        chk("s4_busy",    32'(busy), 32'h1);
        bus.pixel_deq = 1'b1;
        for (int i = 0; i < 30 && pop_log.size() < 1; i++) tick();
        bus.pixel_deq = 1'b0;
        chk("s4_first_word", pop_log[0], 32'h800);
        chk("s4_drop0",      32'(dut.drop_cnt_r), 32'h0);

        // Sparse draining: every 4th cycle, data must stay in order without loss
        do_reset();
        enable = 1'b1; bus.mem_req_ready = 1'b1;
        start_frame(32'h0);
        for (int c = 0; c < 200 && pop_log.size() < 8; c++) begin
            bus.pixel_deq = (c % 4 == 3);
            tick();
        end
        bus.pixel_deq = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.pixel_deq = 1'b0;
        chk("s5_pop_cnt", 32'(pop_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("s5_data", pop_log[i], 32'(i));
        chk("s5_done", 32'(dut.state_r), 32'(ST_DONE));

        // frame_start ignored while disabled
        enable = 1'b0;
        start_frame(32'h3000);
        for (int i = 0; i < 5; i++) tick();
        chk("s6_state",   32'(dut.state_r), 32'(ST_DONE));
        chk("s6_valid",   32'(bus.mem_req_valid), 32'h0);
        chk("s6_req_cnt", 32'(req_log.size()), 32'd8);
        chk("s6_busy",    32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
